// File: rtl/uart_phase_cmd.sv
// Parses SYNC/ADDR/PHASE[/CSUM] command frames from uart_rx into single-cycle phase writes.
// Define UART_PHASE_CHECKSUM_EN to build the 4-byte checksummed frame variant.
module uart_phase_cmd #(
    parameter int         NUM_CH         = 64,
    parameter int         ADDR_W         = 6,
    parameter logic [7:0] SYNC_BYTE      = 8'hAA,
    parameter int         TIMEOUT_CYCLES = 4096
) (
    input  logic              clock_in,
    input  logic              reset_n,
    input  logic              input_RX_done,
    input  logic [7:0]        input_RX_byte,
    output logic              output_wr_en,
    output logic [ADDR_W-1:0] output_wr_addr,
    output logic [7:0]        output_wr_phase,
    output logic              output_frame_err,
    output logic [7:0]        output_err_count
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

`ifdef UART_PHASE_CHECKSUM_EN
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_PHASE, S_CSUM} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_PHASE} state_t;
`endif

    state_t            r_state;
    logic [TMO_W-1:0]  r_tmo;
    logic [ADDR_W-1:0] r_addr;
`ifdef UART_PHASE_CHECKSUM_EN
    logic [7:0]        r_phase;
`endif
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_wr_phase;
    logic              r_frame_err;
    logic [7:0]        r_err_count;

    logic w_tmo_hit;
    logic w_addr_ok;

    // A strobe in the expiry cycle suppresses the timeout.
    assign w_tmo_hit = (r_state != S_IDLE) && !input_RX_done &&
                       (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
    assign w_addr_ok = (32'(input_RX_byte) < 32'(NUM_CH));

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_tmo <= '0;
        end else if (r_state == S_IDLE || input_RX_done || w_tmo_hit) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= r_tmo + TMO_W'(1);
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
`ifdef UART_PHASE_CHECKSUM_EN
            r_phase     <= '0;
`endif
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_phase  <= '0;
            r_frame_err <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_wr_en     <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_tmo_hit) begin
                r_state     <= S_IDLE;
                r_frame_err <= 1'b1;
                if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (input_RX_done && input_RX_byte == SYNC_BYTE) r_state <= S_ADDR;
                    end
                    S_ADDR: begin
                        if (input_RX_done) begin
                            r_addr <= input_RX_byte[ADDR_W-1:0];
                            if (w_addr_ok) begin
                                r_state <= S_PHASE;
                            end else begin
                                r_state     <= S_IDLE;
                                r_frame_err <= 1'b1;
                                if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
                            end
                        end
                    end
                    S_PHASE: begin
                        if (input_RX_done) begin
`ifdef UART_PHASE_CHECKSUM_EN
                            r_phase <= input_RX_byte;
                            r_state <= S_CSUM;
`else
                            r_wr_en    <= 1'b1;
                            r_wr_addr  <= r_addr;
                            r_wr_phase <= input_RX_byte;
                            r_state    <= S_IDLE;
`endif
                        end
                    end
`ifdef UART_PHASE_CHECKSUM_EN
                    S_CSUM: begin
                        if (input_RX_done) begin
                            r_state <= S_IDLE;
                            if (input_RX_byte == (8'(r_addr) ^ r_phase)) begin
                                r_wr_en    <= 1'b1;
                                r_wr_addr  <= r_addr;
                                r_wr_phase <= r_phase;
                            end else begin
                                r_frame_err <= 1'b1;
                                if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
                            end
                        end
                    end
`endif
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign output_wr_en     = r_wr_en;
    assign output_wr_addr   = r_wr_addr;
    assign output_wr_phase  = r_wr_phase;
    assign output_frame_err = r_frame_err;
    assign output_err_count = r_err_count;

endmodule

// File: tb/tb_uart_phase_cmd.sv
// Self-checking bench for uart_phase_cmd: vector table, corner sequences, random frames vs a queue model.
module tb_uart_phase_cmd;

    localparam int         NUM_CH = 64;
    localparam int         ADDR_W = 6;
    localparam int         TMO    = 4096;
    localparam logic [7:0] SYNC   = 8'hAA;
`ifdef UART_PHASE_CHECKSUM_EN
    localparam int FLEN = 4;
`else
    localparam int FLEN = 3;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              done = 1'b0;
    logic [7:0]        rx_byte = 8'h00;
    logic              o_wr;
    logic [ADDR_W-1:0] o_addr;
    logic [7:0]        o_phase;
    logic              o_err;
    logic [7:0]        o_cnt;

    uart_phase_cmd #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock_in(clk), .reset_n(rst_n),
        .input_RX_done(done), .input_RX_byte(rx_byte),
        .output_wr_en(o_wr), .output_wr_addr(o_addr), .output_wr_phase(o_phase),
        .output_frame_err(o_err), .output_err_count(o_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endfunction

    // Reference model: bytes of the current frame in a queue, idle-cycle gap count.
    logic [7:0]        q[$];
    int                gap;
    logic              m_wr, m_err;
    logic [ADDR_W-1:0] m_addr;
    logic [7:0]        m_phase, m_cnt;

    function automatic void model_reset();
        q.delete();
        gap = 0;
        m_wr = 0; m_err = 0; m_addr = '0; m_phase = 0; m_cnt = 0;
    endfunction

    function automatic void model_err();
        m_err = 1'b1;
        if (m_cnt < 8'd255) m_cnt = m_cnt + 8'd1;
        q.delete();
    endfunction

    function automatic void model_step(logic d, logic [7:0] b);
        logic [7:0] a;
        logic       ok;
        m_wr = 0;
        m_err = 0;
        if (q.size() == 0) begin
            if (d && b == SYNC) begin
                q.push_back(b);
                gap = 0;
            end
        end else if (d) begin
            q.push_back(b);
            gap = 0;
            if (q.size() == 2 && int'(b) >= NUM_CH) begin
                model_err();
            end else if (q.size() == FLEN) begin
                a  = q[1];
                ok = 1'b1;
`ifdef UART_PHASE_CHECKSUM_EN
                ok = ((q[1] ^ q[2]) == q[3]);
`endif
                if (ok) begin
                    m_wr    = 1'b1;
                    m_addr  = a[ADDR_W-1:0];
                    m_phase = q[2];
                    q.delete();
                end else begin
                    model_err();
                end
            end
        end else begin
            gap++;
            if (gap == TMO) model_err();
        end
    endfunction

    task automatic step(input logic d, input logic [7:0] b);
        done    = d;
        rx_byte = b;
        model_step(d, b);
        @(posedge clk);
        #1;
        done = 1'b0;
        chk("cycle", 32'({o_wr, o_err, o_addr, o_phase, o_cnt}),
                     32'({m_wr, m_err, m_addr, m_phase, m_cnt}));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    typedef struct {
        logic [7:0] b;
        logic       wr;
        logic       err;
        logic [7:0] addr;
        logic [7:0] phase;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic [7:0] b, logic wr, logic err,
                                logic [7:0] addr, logic [7:0] phase, logic [7:0] cnt);
        vec_t v;
        v.b = b; v.wr = wr; v.err = err; v.addr = addr; v.phase = phase; v.cnt = cnt;
        tbl.push_back(v);
    endfunction

    initial begin : main
        logic [7:0] fr[$];
        logic [7:0] b, a, p;
        int         g;
        int         long_gaps;
        long_gaps = 0;

`ifdef UART_PHASE_CHECKSUM_EN
        add(8'hAA,0,0,8'h00,8'h00,0); add(8'h05,0,0,8'h00,8'h00,0);
        add(8'h80,0,0,8'h00,8'h00,0); add(8'h85,1,0,8'h05,8'h80,0);
        add(8'hAA,0,0,8'h05,8'h80,0); add(8'h05,0,0,8'h05,8'h80,0);
        add(8'h80,0,0,8'h05,8'h80,0); add(8'h86,0,1,8'h05,8'h80,1);
        add(8'hAA,0,0,8'h05,8'h80,1); add(8'h01,0,0,8'h05,8'h80,1);
        add(8'h10,0,0,8'h05,8'h80,1); add(8'h11,1,0,8'h01,8'h10,1);
        add(8'h00,0,0,8'h01,8'h10,1); add(8'h37,0,0,8'h01,8'h10,1);
        add(8'hAA,0,0,8'h01,8'h10,1); add(8'h40,0,1,8'h01,8'h10,2);
`else
        add(8'hAA,0,0,8'h00,8'h00,0); add(8'h3F,0,0,8'h00,8'h00,0);
        add(8'hFF,1,0,8'h3F,8'hFF,0);
        add(8'h00,0,0,8'h3F,8'hFF,0); add(8'h37,0,0,8'h3F,8'hFF,0);
        add(8'hAA,0,0,8'h3F,8'hFF,0); add(8'h40,0,1,8'h3F,8'hFF,1);
        add(8'hAA,0,0,8'h3F,8'hFF,1); add(8'h05,0,0,8'h3F,8'hFF,1);
        add(8'h80,1,0,8'h05,8'h80,1);
        add(8'hAA,0,0,8'h05,8'h80,1); add(8'hAA,0,1,8'h05,8'h80,2);
        add(8'hAA,0,0,8'h05,8'h80,2); add(8'h01,0,0,8'h05,8'h80,2);
        add(8'h22,1,0,8'h01,8'h22,2);
`endif

        model_reset();
        #1;
        chk("reset", 32'({o_wr, o_err, o_addr, o_phase, o_cnt}), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Back-to-back strobes from the vector table.
        for (int i = 0; i < tbl.size(); i++) begin
            step(1'b1, tbl[i].b);
            chk("vec", 32'({o_wr, o_err, 2'b00, o_addr, o_phase, o_cnt}),
                       32'({tbl[i].wr, tbl[i].err, tbl[i].addr, tbl[i].phase, tbl[i].cnt}));
        end

        // Timeout expiry after AA 03, then a good frame.
        step(1'b1, SYNC); step(1'b1, 8'h03);
        idle(TMO - 1);
        chk("tmo_quiet", 32'(o_err), 32'h0);
        step(1'b0, 8'h00);
        chk("tmo_err", 32'(o_err), 32'h1);
        step(1'b1, SYNC); step(1'b1, 8'h03); step(1'b1, 8'h20);
`ifdef UART_PHASE_CHECKSUM_EN
        step(1'b1, 8'h23);
`endif
        chk("tmo_next", 32'({o_wr, 2'b00, o_addr, o_phase}), 32'({1'b1, 8'h03, 8'h20}));

        // Strobe in the expiry cycle wins.
        step(1'b1, SYNC); step(1'b1, 8'h03);
        idle(TMO - 1);
        step(1'b1, 8'h21);
        chk("tmo_win", 32'(o_err), 32'h0);
`ifdef UART_PHASE_CHECKSUM_EN
        step(1'b1, 8'h22);
`endif
        chk("win_wr", 32'({o_wr, 2'b00, o_addr, o_phase}), 32'({1'b1, 8'h03, 8'h21}));

        // Error counter saturation.
        for (int i = 0; i < 300; i++) begin
`ifdef UART_PHASE_CHECKSUM_EN
            step(1'b1, SYNC); step(1'b1, 8'h05); step(1'b1, 8'h80); step(1'b1, 8'h00);
`else
            step(1'b1, SYNC); step(1'b1, 8'h50);
`endif
        end
        chk("sat", 32'(o_cnt), 32'd255);
        step(1'b1, SYNC); step(1'b1, 8'hC8);
        chk("sat_pulse", 32'({o_err, o_cnt}), 32'({1'b1, 8'd255}));

        // Reset in the middle of a frame after a successful write.
        step(1'b1, SYNC); step(1'b1, 8'h3F); step(1'b1, 8'hFF);
`ifdef UART_PHASE_CHECKSUM_EN
        step(1'b1, 8'hC0);
`endif
        chk("pre_rst_wr", 32'({o_wr, 2'b00, o_addr, o_phase}), 32'({1'b1, 8'h3F, 8'hFF}));
        step(1'b1, SYNC); step(1'b1, 8'h3F);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_async", 32'({o_wr, o_err, o_addr, o_phase, o_cnt}), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 8'hFF);
        chk("rst_nowr", 32'({o_wr, o_err, o_addr, o_phase, o_cnt}), 32'h0);

        // Random frames with random gaps, checked each cycle against the model.
        for (int f = 0; f < 300; f++) begin
            fr.delete();
            if ($urandom_range(0, 9) == 0) begin
                b = 8'($urandom);
                if (b == SYNC) b = 8'h55;
                fr.push_back(b);
            end
            a = 8'($urandom_range(0, 79));
            p = 8'($urandom);
            fr.push_back(SYNC);
            fr.push_back(a);
            fr.push_back(p);
`ifdef UART_PHASE_CHECKSUM_EN
            b = a ^ p;
            if ($urandom_range(0, 4) == 0) b = b ^ 8'h01;
            fr.push_back(b);
`endif
            for (int k = 0; k < fr.size(); k++) begin
                g = $urandom_range(0, 3);
                if (long_gaps < 6 && $urandom_range(0, 99) == 0) begin
                    g = TMO - 3 + $urandom_range(0, 5);
                    long_gaps++;
                end
                idle(g);
                step(1'b1, fr[k]);
            end
        end
        idle(4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_phase_cmd.md
# uart_phase_cmd

Downstream consumer of `uart_rx`. Takes the received byte stream (byte plus one-cycle done strobe) and parses fixed-length command frames: sync, channel address, phase, optional checksum. Each valid frame produces a single-cycle write into the transducer phase register file. Malformed frames, out-of-range addresses and stalled frames are dropped and counted.

## Interface

Parameters:
- `NUM_CH`, 64, number of transducer channels; valid addresses are 0..NUM_CH-1.
- `ADDR_W`, 6, width of `output_wr_addr`; must satisfy 2^ADDR_W >= NUM_CH.
- `SYNC_BYTE`, 8'hAA, frame start marker.
- `TIMEOUT_CYCLES`, 4096, maximum idle clocks between bytes inside a frame (≈3.2 byte times at 1280 clocks/byte).

Ports:
- `clock_in`  in  1  system clock, 50 MHz; same clock as `uart_rx`.
- `reset_n`  in  1  asynchronous, active-low reset.
- `input_RX_done`  in  1  one-cycle strobe from `uart_rx`, byte valid.
- `input_RX_byte`  in  8  received byte, sampled only when `input_RX_done`=1.
- `output_wr_en`  out  1  one-cycle write strobe for a valid frame.
- `output_wr_addr`  out  ADDR_W  channel index; holds last written value.
- `output_wr_phase`  out  8  phase value; holds last written value.
- `output_frame_err`  out  1  one-cycle pulse per dropped frame.
- `output_err_count`  out  8  saturating count of dropped frames.

## Operation

- FSM states: IDLE, ADDR, PHASE, CSUM (CSUM only with checksum compiled in).
- IDLE: on done with byte == SYNC_BYTE -> ADDR. Any other byte is discarded silently, with no error.
- ADDR: on done, latch byte as address. If byte >= NUM_CH: error, -> IDLE. Otherwise -> PHASE.
- PHASE: on done, latch phase. With checksum -> CSUM. Without checksum -> issue write, -> IDLE.
- CSUM: on done, compare byte with (addr ^ phase). On match: write, -> IDLE. On mismatch: error, -> IDLE.
- A byte equal to SYNC_BYTE in a non-IDLE state is treated as data, not as a resync.
- Timeout counter:
  - Cleared on every done strobe and held at 0 in IDLE.
  - Increments every cycle in any other state.
  - When it reaches TIMEOUT_CYCLES-1 without a done: error, -> IDLE.
- Error action: `output_frame_err` pulses for 1 cycle. `output_err_count` increments and saturates at 255. No write is issued.
- Address comparison uses the full 8-bit byte. The upper bits are truncated to ADDR_W only at the output register.

## Timing

- All outputs are registered.
- Reset values: state IDLE, `output_wr_en`=0, `output_wr_addr`=0, `output_wr_phase`=0, `output_frame_err`=0, `output_err_count`=0, timeout counter 0.
- `output_wr_en` asserts on the clock edge after the done strobe of the final frame byte, for exactly 1 cycle.
- `output_wr_addr` and `output_wr_phase` update on that same edge.
- `output_frame_err` has the same 1-cycle latency relative to the offending done strobe, or relative to the timeout expiry cycle.
- A done strobe arriving in the same cycle the timeout would expire wins: the byte is processed and no error is raised.
- Back-to-back done strobes (one per cycle) must be handled. Minimum frame throughput is one frame per 3 (or 4) strobes.
- Reset asserted mid-frame: the partial frame is discarded, with no write and no error; all outputs return to reset values asynchronously.

## Configuration

- `UART_PHASE_CHECKSUM_EN` defined:
  - 4-byte frames: SYNC, ADDR, PHASE, CSUM.
  - CSUM state is present; checksum mismatch counts as an error.
- Undefined:
  - 3-byte frames: SYNC, ADDR, PHASE.
  - CSUM state and comparison logic are not synthesised.
  - Write issues on the PHASE byte.

## Test plan

- Checksum on, bytes AA 05 80 85 -> one `output_wr_en` pulse; `output_wr_addr`=5, `output_wr_phase`=0x80; `output_err_count`=0.
- Checksum on, bytes AA 05 80 86 -> no write; `output_frame_err` pulses once; `output_err_count`=1; next frame AA 01 10 11 writes addr 1, phase 0x10.
- Bytes 00 37 AA 40 (NUM_CH=64) -> leading 00 and 37 ignored; addr 0x40 rejected; one error, no write.
- Bytes AA 03, then no strobe for 4096 cycles -> error pulse at the timeout; FSM in IDLE; following AA 03 20 23 writes addr 3, phase 0x20.
- 300 bad frames (AA 05 80 00) -> `output_err_count` saturates at 255.
- Checksum off, bytes AA 3F FF -> write addr 63, phase 0xFF one cycle after the third strobe. Reset asserted after AA 3F -> no write; all outputs 0.
